adder_seriale_ctrl: RTL
=======================

ADDER_SERIALE_CTRL -- requirements
Module: adder_seriale_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand set offered.
REQ-005 SHALL have port: in_ready  output  1  controller accepts operands this cycle.
REQ-006 SHALL have port: a  input  WIDTH  first addend.
REQ-007 SHALL have port: b  input  WIDTH  second addend.
REQ-008 SHALL have port: r_in  input  1  carry-in.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: s  output  WIDTH  sum.
REQ-012 SHALL have port: r_out  output  1  carry-out.
REQ-013 SHALL have port (only with OVERFLOW_FLAG_EN): ovf  output  1  two's-complement overflow.

Function
REQ-014 SHALL be a bit-serial adder sequencer: one 1-bit full-adder slice (sum = a^b^c, carry = majority(a,b,c)) reused once per bit, LSB first.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; IDLE is the reset state.
REQ-016 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 SHALL, on a rising edge with in_valid=1 in IDLE, latch a, b into shift registers, r_in into the carry flop, clear the bit counter and enter RUN.
REQ-018 SHALL, in RUN, on each edge shift in one sum bit (MSB-side insertion into the result register), update the carry flop and increment the counter.
REQ-019 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1; RUN lasts exactly WIDTH cycles.
REQ-020 SHALL assert out_valid exactly WIDTH cycles after the accepting edge (first cycle after the last bit edge).
REQ-021 SHALL hold s, r_out (and ovf) stable throughout DONE while out_ready=0.
REQ-022 SHALL return to IDLE on the edge where out_valid=1 and out_ready=1; s, r_out retain last result until next RUN completes.
REQ-023 SHALL ignore in_valid, a, b, r_in outside IDLE; operand changes during RUN do not affect the result.
REQ-024 SHALL produce s = (a+b+r_in) mod 2^WIDTH, r_out = bit WIDTH of a+b+r_in, for all inputs including all-ones wrap-around.
REQ-025 SHALL have minimum initiation interval WIDTH+2 cycles (accept, WIDTH RUN cycles, one DONE cycle with out_ready=1).
REQ-026 SHALL ignore out_ready outside DONE.

Reset
REQ-027 SHALL, on rst_n=0, immediately (without clock) set state=IDLE, in_ready=1, out_valid=0, s=0, r_out=0, ovf=0, counter and carry flop=0.
REQ-028 SHALL abandon any RUN/DONE operation on reset; no result of the aborted operation ever appears.
REQ-029 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with macro ADDER_SERIALE_OVERFLOW_FLAG_EN defined, provide ovf = carry into MSB XOR carry out of MSB, valid with s.
REQ-031 SHALL, without ADDER_SERIALE_OVERFLOW_FLAG_EN, omit the ovf port and its logic; all other behaviour unchanged.

Verification (WIDTH=8)
REQ-032 SHALL cover: a=0x0F, b=0x01, r_in=0 -> out_valid 8 cycles after accept, s=0x10, r_out=0.
REQ-033 SHALL cover: a=0xFF, b=0x00, r_in=1 -> s=0x00, r_out=1; ovf=0 (macro on).
REQ-034 SHALL cover: a=0x7F, b=0x01, r_in=0 -> s=0x80, r_out=0, ovf=1 (macro on).
REQ-035 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid, s, r_out stable; in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-036 SHALL cover: a/b toggled every cycle during RUN -> result equals latched operands only.
REQ-037 SHALL cover: rst_n pulsed low at RUN bit 4 -> out_valid=0, in_ready=1 immediately; next op 0x03+0x04 gives s=0x07.

Source files
------------

// File: rtl/adder_seriale_ctrl.sv
// ---------------------------------------------------------------------------
// adder_seriale_ctrl
//
// Bit-serial adder sequencer. A single 1-bit full-adder slice is reused once
// per bit, LSB first, to add two WIDTH-bit operands plus a carry-in.
// Handshake: operands are taken in IDLE on in_valid, the addition runs for
// exactly WIDTH cycles in RUN, and the result is presented in DONE until the
// consumer takes it with out_ready.
//
// Parameters:
//   WIDTH      operand/result width in bits (2..32)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set offered
//   in_ready   controller accepts operands this cycle (IDLE only)
//   a, b       addends
//   r_in       carry-in
//   out_valid  result available (DONE only)
//   out_ready  consumer takes result
//   s          sum, (a + b + r_in) mod 2^WIDTH
//   r_out      carry-out (bit WIDTH of a + b + r_in)
//   ovf        two's-complement overflow, present only when the macro
//              ADDER_SERIALE_OVERFLOW_FLAG_EN is defined
// ---------------------------------------------------------------------------
module adder_seriale_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             r_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             r_out
`ifdef ADDER_SERIALE_OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // One full-adder slice: sum output
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    // One full-adder slice: carry output (majority of the three inputs)
    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    state_t           state_r;
    state_t           state_next_s;

    // a_sh_r doubles as the result accumulator: each RUN edge consumes its
    // LSB and inserts the new sum bit at the MSB side.
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] s_r;
    logic             r_out_r;
`ifdef ADDER_SERIALE_OVERFLOW_FLAG_EN
    logic             ovf_r;
`endif

    logic             sum_bit_s;
    logic             carry_next_s;
    logic             last_bit_s;
    logic             accept_s;
    logic             in_ready_s;
    logic             out_valid_s;

    // Full-adder slice on the current operand bits plus handshake decodes
    always_comb begin
        sum_bit_s    = fa_sum(a_sh_r[0], b_sh_r[0], carry_r);
        carry_next_s = fa_carry(a_sh_r[0], b_sh_r[0], carry_r);
        last_bit_s   = (cnt_r == LAST_BIT);
        accept_s     = (state_r == IDLE) && in_valid;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM output decode; both flags come straight from the state flops
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            RUN: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
            DONE: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Serial datapath: operand load, per-bit shift/carry, result capture.
    // s/r_out/ovf only change on the edge that finishes the last bit, so the
    // previous result stays visible during the next RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            s_r     <= '0;
            r_out_r <= 1'b0;
`ifdef ADDER_SERIALE_OVERFLOW_FLAG_EN
            ovf_r   <= 1'b0;
`endif
        end else if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= r_in;
            cnt_r   <= '0;
        end else if (state_r == RUN) begin
            a_sh_r  <= {sum_bit_s, a_sh_r[WIDTH-1:1]};
            b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
            carry_r <= carry_next_s;
            cnt_r   <= cnt_r + CW'(1'b1);
            if (last_bit_s) begin
                s_r     <= {sum_bit_s, a_sh_r[WIDTH-1:1]};
                r_out_r <= carry_next_s;
`ifdef ADDER_SERIALE_OVERFLOW_FLAG_EN
                // carry_r is the carry into the MSB on this last slice
                ovf_r   <= carry_r ^ carry_next_s;
`endif
            end else begin
                s_r     <= s_r;
                r_out_r <= r_out_r;
            end
        end else begin
            a_sh_r  <= a_sh_r;
            b_sh_r  <= b_sh_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign s         = s_r;
    assign r_out     = r_out_r;
`ifdef ADDER_SERIALE_OVERFLOW_FLAG_EN
    assign ovf       = ovf_r;
`endif

endmodule
